// File: rtl/usb_pkt_pkg.sv
// rtl/usb_pkt_pkg.sv - shared constants, error codes and state encoding for the command sequencer
package usb_pkt_pkg;

    localparam logic [7:0] SYNC0 = 8'h5E;
    localparam logic [7:0] SYNC1 = 8'h4D;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_HCS  = 3'd1;
    localparam logic [2:0] ERR_LEN  = 3'd2;
    localparam logic [2:0] ERR_CRC  = 3'd3;
    localparam logic [2:0] ERR_TMO  = 3'd4;

    typedef enum logic [3:0] {
        ST_HUNT0,
        ST_HUNT1,
        ST_ADDR,
        ST_RSVD,
        ST_LEN,
        ST_HCS,
        ST_PAY,
        ST_CRC,
        ST_REP_A,
        ST_REP_D
    } state_t;

endpackage

// File: rtl/pkt_payload_buf.sv
// rtl/pkt_payload_buf.sv - single-clock payload RAM with registered read
// Ports: clk (clock), i_we/i_waddr/i_wdata (write port),
//        i_raddr (read address), o_rdata (data for i_raddr, one cycle later).
module pkt_payload_buf #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [1<<AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/usb_cmd_sequencer.sv
// rtl/usb_cmd_sequencer.sv - FTDI packet parser that replays only verified packets to the register port
// Ports: clk_ftdi/n_rst (clock, async active-low reset),
//        rx_byte/rx_valid/rx_ready (inbound byte stream),
//        wr_addr_vld/wr_data_vld/wr_byte (register write port),
//        pkt_ok/err_stb/err_code (per-packet status), busy,
//        ok_cnt/err_cnt (saturating statistics).
module usb_cmd_sequencer
    import usb_pkt_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clk_ftdi,
    input  logic             n_rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             wr_addr_vld,
    output logic             wr_data_vld,
    output logic [7:0]       wr_byte,
    output logic             pkt_ok,
    output logic             err_stb,
    output logic [2:0]       err_code,
    output logic             busy,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_addr;
    logic [7:0]      r_rsvd;
    logic [7:0]      r_len;
    logic [7:0]      r_crc;
    logic [7:0]      r_wptr;
    logic [7:0]      r_rptr;
    logic [TW-1:0]   r_gap;
    logic            r_err_stb;
    logic [2:0]      r_err_code;
    logic [CNT_W-1:0] r_ok_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic            w_acc;
    logic            w_body;
    logic            w_tmo;
    logic            w_last;
    logic            w_err;
    logic [2:0]      w_err_code;
    logic            w_pay_we;
    logic [7:0]      w_len_m1;
    logic [AW-1:0]   w_raddr;
    logic [7:0]      w_rdata;

    assign w_acc    = rx_valid & rx_ready;
    assign w_body   = (r_state inside {ST_ADDR, ST_RSVD, ST_LEN, ST_HCS, ST_PAY, ST_CRC});
    // An arriving byte beats an expiring gap counter.
    assign w_tmo    = w_body & ~w_acc & (r_gap == TW'(TIMEOUT - 1));
    assign w_len_m1 = 8'(r_len - 8'd1);
    assign w_last   = (r_state == ST_REP_D) && (r_rptr == w_len_m1);

    // Registered RAM read: address 0 is presented during REP_A so its data
    // is ready in the first REP_D cycle; afterwards we read one ahead.
    assign w_raddr  = (r_state == ST_REP_D) ? AW'(8'(r_rptr + 8'd1)) : '0;

    pkt_payload_buf #(
        .AW (AW)
    ) u_buf (
        .clk     (clk_ftdi),
        .i_we    (w_pay_we),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (rx_byte),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_ftdi or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_HUNT0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        w_pay_we   = 1'b0;
        case (r_state)
            ST_HUNT0: begin
                if (w_acc && rx_byte == SYNC0) w_next = ST_HUNT1;
            end
            ST_HUNT1: begin
                if (w_acc) begin
                    if (rx_byte == SYNC1)      w_next = ST_ADDR;
                    else if (rx_byte == SYNC0) w_next = ST_HUNT1;
                    else                       w_next = ST_HUNT0;
                end
            end
            ST_ADDR: if (w_acc) w_next = ST_RSVD;
            ST_RSVD: if (w_acc) w_next = ST_LEN;
            ST_LEN: begin
                if (w_acc) begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_LEN;
                        w_next     = ST_HUNT0;
                    end else begin
                        w_next = ST_HCS;
                    end
                end
            end
            ST_HCS: begin
                if (w_acc) begin
                    if (rx_byte != (r_addr ^ r_rsvd ^ r_len)) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_HCS;
                        w_next     = ST_HUNT0;
                    end else begin
                        w_next = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (w_acc) begin
                    w_pay_we = 1'b1;
                    if (r_wptr == w_len_m1) w_next = ST_CRC;
                end
            end
            ST_CRC: begin
                if (w_acc) begin
                    if (rx_byte != r_crc) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CRC;
                        w_next     = ST_HUNT0;
                    end else begin
                        w_next = ST_REP_A;
                    end
                end
            end
            ST_REP_A: w_next = ST_REP_D;
            ST_REP_D: if (w_last) w_next = ST_HUNT0;
            default:  w_next = ST_HUNT0;
        endcase
        if (w_tmo) begin
            w_err      = 1'b1;
            w_err_code = ERR_TMO;
            w_next     = ST_HUNT0;
        end
    end

    always_ff @(posedge clk_ftdi or negedge n_rst) begin
        if (!n_rst) begin
            r_addr     <= '0;
            r_rsvd     <= '0;
            r_len      <= '0;
            r_crc      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_gap      <= '0;
            r_err_stb  <= 1'b0;
            r_err_code <= ERR_NONE;
            r_ok_cnt   <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_acc) begin
                case (r_state)
                    ST_ADDR: r_addr <= rx_byte;
                    ST_RSVD: r_rsvd <= rx_byte;
                    ST_LEN:  r_len  <= rx_byte;
                    ST_HCS: begin
                        r_wptr <= '0;
                        r_crc  <= '0;
                    end
                    ST_PAY: begin
                        r_wptr <= 8'(r_wptr + 8'd1);
                        r_crc  <= r_crc ^ rx_byte;
                    end
                    ST_CRC:  r_rptr <= '0;
                    default: ;
                endcase
            end
            if (r_state == ST_REP_D) begin
                r_rptr <= 8'(r_rptr + 8'd1);
            end

            if (!w_body || w_acc) begin
                r_gap <= '0;
            end else begin
                r_gap <= TW'(r_gap + 1'b1);
            end

            r_err_stb <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_last && r_ok_cnt != '1) begin
                r_ok_cnt <= r_ok_cnt + 1'b1;
            end
        end
    end

    assign rx_ready    = !(r_state inside {ST_REP_A, ST_REP_D});
    assign wr_addr_vld = (r_state == ST_REP_A);
    assign wr_data_vld = (r_state == ST_REP_D);
    assign wr_byte     = (r_state == ST_REP_A) ? r_addr :
                         (r_state == ST_REP_D) ? w_rdata : 8'h00;
    assign pkt_ok      = w_last;
    assign err_stb     = r_err_stb;
    assign err_code    = r_err_code;
    assign busy        = (r_state != ST_HUNT0);
    assign ok_cnt      = r_ok_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_usb_cmd_sequencer.sv
// tb/tb_usb_cmd_sequencer.sv - scoreboard bench for the command sequencer
module tb_usb_cmd_sequencer;

    localparam int MAX_LEN = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 4;

    localparam logic [3:0] EV_A = 4'd1;
    localparam logic [3:0] EV_D = 4'd2;
    localparam logic [3:0] EV_K = 4'd3;
    localparam logic [3:0] EV_E = 4'd4;
    localparam logic [3:0] EV_X = 4'd5;

    logic             clk_ftdi = 1'b0;
    logic             n_rst;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ready;
    logic             wr_addr_vld;
    logic             wr_data_vld;
    logic [7:0]       wr_byte;
    logic             pkt_ok;
    logic             err_stb;
    logic [2:0]       err_code;
    logic             busy;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [11:0]      exp_q [$];
    logic [7:0]       pay_q [$];
    logic [CNT_W-1:0] exp_ok  = '0;
    logic [CNT_W-1:0] exp_err = '0;
    logic [2:0]       exp_code = 3'd0;
    bit               in_rep  = 1'b0;

    usb_cmd_sequencer #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_ftdi    (clk_ftdi),
        .n_rst       (n_rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .wr_addr_vld (wr_addr_vld),
        .wr_data_vld (wr_data_vld),
        .wr_byte     (wr_byte),
        .pkt_ok      (pkt_ok),
        .err_stb     (err_stb),
        .err_code    (err_code),
        .busy        (busy),
        .ok_cnt      (ok_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk_ftdi = ~clk_ftdi;

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk_ftdi) begin
        logic [11:0] obs [$];
        logic [11:0] exp_v;
        if (!n_rst) begin
            in_rep = 1'b0;
        end else begin
            obs.delete();
            if (wr_addr_vld)      obs.push_back({EV_A, wr_byte});
            else if (wr_data_vld) obs.push_back({pkt_ok ? EV_K : EV_D, wr_byte});
            else if (pkt_ok)      obs.push_back({EV_X, wr_byte});
            if (err_stb)          obs.push_back({EV_E, 5'd0, err_code});
            if (in_rep) begin
                checks++;
                if (!wr_data_vld) begin
                    failures++;
                    $display("FAIL replay_gap: wr_data_vld=%0b required 1 at %0t", wr_data_vld, $time);
                end
            end
            if (wr_addr_vld) in_rep = 1'b1;
            else if (wr_data_vld && pkt_ok) in_rep = 1'b0;
            foreach (obs[i]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got %03h required none at %0t", obs[i], $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs[i] !== exp_v) begin
                        failures++;
                        $display("FAIL event: got %03h required %03h at %0t", obs[i], exp_v, $time);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk_ftdi);
            if (rx_ready) break;
            n++;
            if (n > 50) begin
                failures++;
                $display("FAIL send_timeout: rx_ready=%0b required 1", rx_ready);
                break;
            end
        end
        @(posedge clk_ftdi);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_err(input logic [2:0] code);
        exp_q.push_back({EV_E, 5'd0, code});
        exp_code = code;
        if (exp_err != '1) exp_err = exp_err + 1'b1;
    endtask

    // Builds the frame from pay_q, pushes what the sequencer should emit and
    // sends the bytes the sequencer will actually consume, from index skip.
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] r, input logic [7:0] l,
                            input logic [7:0] h, input logic [7:0] c, input int skip);
        logic [7:0] frame [$];
        logic [7:0] x;
        frame = '{8'h5E, 8'h4D, a, r, l};
        if (l == 8'd0 || int'(l) > MAX_LEN) begin
            push_err(3'd2);
        end else begin
            frame.push_back(h);
            if (h != (a ^ r ^ l)) begin
                push_err(3'd1);
            end else begin
                x = 8'h00;
                foreach (pay_q[i]) begin
                    frame.push_back(pay_q[i]);
                    x = x ^ pay_q[i];
                end
                frame.push_back(c);
                if (c != x) begin
                    push_err(3'd3);
                end else begin
                    exp_q.push_back({EV_A, a});
                    foreach (pay_q[i])
                        exp_q.push_back({(i == pay_q.size() - 1) ? EV_K : EV_D, pay_q[i]});
                    if (exp_ok != '1) exp_ok = exp_ok + 1'b1;
                end
            end
        end
        for (int i = skip; i < frame.size(); i++) send_byte(frame[i]);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_ftdi);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d events outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk_ftdi);
    endtask

    task automatic check_stats(input string tag);
        checks++;
        if (ok_cnt !== exp_ok) begin
            failures++;
            $display("FAIL %s ok_cnt: got %0d required %0d", tag, ok_cnt, exp_ok);
        end
        checks++;
        if (err_cnt !== exp_err) begin
            failures++;
            $display("FAIL %s err_cnt: got %0d required %0d", tag, err_cnt, exp_err);
        end
        checks++;
        if (err_code !== exp_code) begin
            failures++;
            $display("FAIL %s err_code: got %0d required %0d", tag, err_code, exp_code);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({rx_ready, wr_addr_vld, wr_data_vld, pkt_ok, err_stb, busy} !== 6'b100000) begin
            failures++;
            $display("FAIL %s flags: got %06b required 100000",
                     tag, {rx_ready, wr_addr_vld, wr_data_vld, pkt_ok, err_stb, busy});
        end
        checks++;
        if (wr_byte !== 8'h00) begin
            failures++;
            $display("FAIL %s wr_byte: got %02h required 00", tag, wr_byte);
        end
    endtask

    task automatic set_good_pay();
        pay_q = '{8'h92, 8'h08};
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(posedge clk_ftdi);
        #1;
        check_idle_outputs("reset_held");
        n_rst = 1'b1;
        @(negedge clk_ftdi);
        check_idle_outputs("reset_released");
        check_stats("reset");
    endtask

    task automatic test_good();
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9A, 0);
        checks++;
        if (wr_addr_vld !== 1'b1 || wr_byte !== 8'h08) begin
            failures++;
            $display("FAIL good_latency: addr_vld=%0b byte=%02h required 1/08", wr_addr_vld, wr_byte);
        end
        wait_drain(20);
        check_stats("good");
    endtask

    task automatic test_crc_err();
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9B, 0);
        wait_drain(20);
        check_stats("crc_err");
    endtask

    task automatic test_hcs_err();
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0B, 8'h9A, 0);
        wait_drain(20);
        check_stats("hcs_err");
    endtask

    task automatic test_noise();
        send_byte(8'h00);
        @(negedge clk_ftdi);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL noise_busy: got %0b required 0", busy);
        end
        send_byte(8'h5E);
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9A, 0);
        wait_drain(20);
        check_stats("noise");
    endtask

    task automatic test_len_err();
        pay_q.delete();
        send_pkt(8'h08, 8'h00, 8'h21, 8'h29, 8'h00, 0);
        send_byte(8'h29);
        @(negedge clk_ftdi);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL len_hunt_busy: got %0b required 0", busy);
        end
        wait_drain(20);
        check_stats("len_err");
        pay_q = '{8'h40};
        send_pkt(8'h10, 8'h00, 8'h01, 8'h11, 8'h40, 0);
        wait_drain(20);
        check_stats("len_boundary1");
    endtask

    task automatic test_max_len();
        logic [7:0] x = 8'h00;
        pay_q.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            pay_q.push_back(8'(i * 7 + 3));
            x = x ^ 8'(i * 7 + 3);
        end
        send_pkt(8'h33, 8'h01, 8'(MAX_LEN), 8'h33 ^ 8'h01 ^ 8'(MAX_LEN), x, 0);
        wait_drain(60);
        check_stats("max_len");
    endtask

    task automatic test_timeout();
        logic [7:0] part [$];
        part = '{8'h5E, 8'h4D, 8'h08, 8'h00, 8'h02, 8'h0A, 8'h92};
        push_err(3'd4);
        foreach (part[i]) send_byte(part[i]);
        wait_drain(TIMEOUT + 20);
        check_stats("timeout");
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9A, 0);
        wait_drain(20);
        check_stats("after_timeout");
    endtask

    task automatic test_back_to_back();
        int lows = 0;
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9A, 0);
        rx_byte  = 8'h5E;
        rx_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_ftdi);
            if (rx_ready) break;
            lows++;
        end
        checks++;
        if (lows != 3) begin
            failures++;
            $display("FAIL backpressure_cycles: got %0d required 3", lows);
        end
        @(posedge clk_ftdi);
        #1;
        rx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL held_byte_consumed: busy=%0b required 1", busy);
        end
        pay_q = '{8'hA5, 8'h5E, 8'h01};
        send_pkt(8'h20, 8'h00, 8'h03, 8'h23, 8'hFA, 1);
        wait_drain(20);
        check_stats("back_to_back");
    endtask

    task automatic test_saturation();
        pay_q.delete();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            send_pkt(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
            wait_drain(20);
        end
        checks++;
        if (err_cnt !== {CNT_W{1'b1}}) begin
            failures++;
            $display("FAIL err_cnt_saturate: got %0d required %0d", err_cnt, (1 << CNT_W) - 1);
        end
        check_stats("saturation");
    endtask

    task automatic test_reset_mid_replay();
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9A, 0);
        @(posedge clk_ftdi);
        #1;
        n_rst = 1'b0;
        #1;
        check_idle_outputs("mid_replay_reset");
        exp_q.delete();
        exp_ok   = '0;
        exp_err  = '0;
        exp_code = 3'd0;
        check_stats("mid_replay_reset");
        repeat (2) @(posedge clk_ftdi);
        #1;
        n_rst = 1'b1;
        set_good_pay();
        send_pkt(8'h08, 8'h00, 8'h02, 8'h0A, 8'h9A, 0);
        wait_drain(20);
        check_stats("after_reset");
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_err();
        test_hcs_err();
        test_noise();
        test_len_err();
        test_max_len();
        test_timeout();
        test_back_to_back();
        test_saturation();
        test_reset_mid_replay();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
